bubsys_ioctl_uploader: RTL

- Responder for the MiSTer ioctl upload direction. The HPS reads core memory, e.g. bubble-memory save image or NVRAM dump, byte by byte through ioctl_rd / ioctl_din.
- Translates byte reads into 16-bit word requests on a request/ack memory port. That port is SDRAM prog_rd or a BRAM mux.
- Keeps a one-word cache and drives ioctl_wait while a fetch is outstanding.
- Sits in the emu top beside the ROM downloader and shares the ioctl bus with it.

---
 rtl/bubsys_ioctl_uploader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bubsys_ioctl_uploader.sv
// Serves HPS ioctl upload byte reads from a 16-bit request/ack memory port.
// Holds one fetched word as a cache and stalls the HPS while a fetch is outstanding.
module bubsys_ioctl_uploader #(
  parameter logic [15:0] UPLOAD_INDEX = 16'd2,
  parameter int unsigned AW           = 17,
  parameter logic [31:0] SIZE_BYTES   = 32'h0004_0000,
  parameter logic [15:0] TIMEOUT      = 16'd1023
) (
  input  logic          i_EMU_MCLK,
  input  logic          i_EMU_INITRST,
  input  logic          ioctl_upload,
  input  logic [15:0]   ioctl_index,
  input  logic [26:0]   ioctl_addr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [AW-1:0] o_MEM_ADDR,
  output logic          o_MEM_RQ,
  input  logic          i_MEM_ACK,
  input  logic [15:0]   i_MEM_DATA,
  output logic          o_ACTIVE,
  output logic          o_ERR
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          rq_q, rq_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          active_q;
  logic          err_q, err_d;
  logic [15:0]   cache_q, cache_d;
  logic [AW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;
  logic          bsel_q, bsel_d;

  logic          sel;
  logic          sel_rise;
  logic [AW-1:0] word;
  logic          oob;
  logic          hit;

  // Session decode and request classification
  always_comb begin
    sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    sel_rise = sel && !active_q;
    word     = ioctl_addr[AW:1];
    oob      = {5'd0, ioctl_addr} >= SIZE_BYTES;
    hit      = valid_q && !sel_rise && (tag_q == word);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    din_d   = din_q;
    wait_d  = wait_q;
    rq_d    = rq_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cache_d = cache_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    bsel_d  = bsel_q;

    if (sel_rise) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ioctl_rd && sel) begin
          if (oob) begin
            din_d = 8'hFF;
          end else if (hit) begin
            din_d = ioctl_addr[0] ? cache_q[7:0] : cache_q[15:8];
          end else begin
            wait_d  = 1'b1;
            rq_d    = 1'b1;
            addr_d  = word;
            bsel_d  = ioctl_addr[0];
            timer_d = 16'd0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!sel) begin
          // Session ended under us: drop the request, keep the last byte
          rq_d    = 1'b0;
          wait_d  = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (i_MEM_ACK) begin
          cache_d = i_MEM_DATA;
          tag_d   = addr_q;
          valid_d = 1'b1;
          din_d   = bsel_q ? i_MEM_DATA[7:0] : i_MEM_DATA[15:8];
          rq_d    = 1'b0;
          wait_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_q == TIMEOUT) begin
          din_d   = 8'hFF;
          err_d   = 1'b1;
          rq_d    = 1'b0;
          wait_d  = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      state_q  <= IDLE;
      timer_q  <= 16'd0;
      din_q    <= 8'hFF;
      wait_q   <= 1'b0;
      rq_q     <= 1'b0;
      addr_q   <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      cache_q  <= 16'd0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      bsel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      rq_q     <= rq_d;
      addr_q   <= addr_d;
      active_q <= sel;
      err_q    <= err_d;
      cache_q  <= cache_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      bsel_q   <= bsel_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign o_MEM_RQ   = rq_q;
  assign o_MEM_ADDR = addr_q;
  assign o_ACTIVE   = active_q;
  assign o_ERR      = err_q;

endmodule
